// File: rtl/mash_sinc3_decimator_pkg.sv
// rtl/mash_sinc3_decimator_pkg.sv - shared constants and width helper for the sinc3 decimator
//
// Contents:
//   ORDER         number of integrator/comb stages (sinc3)
//   Y_MIN, Y_MAX  legal range of the HK-MASH 1-1-1 output sample
//   cic_cw()      internal CIC width: input bits plus ORDER*log2(R) bits of growth

package mash_decim_pkg;

    localparam int ORDER = 3;
    localparam int Y_MIN = -3;
    localparam int Y_MAX = 4;

    function automatic int cic_cw(input int dec_log2);
        return 4 + ORDER * dec_log2;
    endfunction

endpackage

// File: rtl/mash_sinc3_decimator_if.sv
// rtl/mash_sinc3_decimator_if.sv - sample input / decimated output bundle of the sinc3 decimator
//
// Signals:
//   in_valid_i  y_i carries a modulator sample this cycle
//   y_i         4-bit signed modulator output
//   valid_o     one-cycle pulse, y_o/x_o carry a new result
//   y_o         CW-bit signed raw sinc3 output
//   x_o         WIDTH-bit unsigned estimate of the modulator input word
//   settled_o   filter memory fully flushed
// Modports:
//   master  sample source / result consumer
//   slave   the decimator

interface mash_sinc3_decimator_if
    import mash_decim_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int CW    = cic_cw(6)
);

    logic                 in_valid_i;
    logic [3:0]           y_i;
    logic                 valid_o;
    logic signed [CW-1:0] y_o;
    logic [WIDTH-1:0]     x_o;
    logic                 settled_o;

    modport master (
        output in_valid_i, y_i,
        input  valid_o, y_o, x_o, settled_o
    );

    modport slave (
        input  in_valid_i, y_i,
        output valid_o, y_o, x_o, settled_o
    );

endinterface

// File: rtl/mash_sinc3_decimator_cic_int_stage.sv
// rtl/mash_sinc3_decimator_cic_int_stage.sv - enabled CW-bit wrapping accumulator for the CIC integrators
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   en    accumulate din this cycle; hold otherwise
//   din   signed addend
//   acc   signed accumulator (two's-complement wrap is intentional; the combs undo it)

module cic_int_stage #(
    parameter int CW = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic signed [CW-1:0] din,
    output logic signed [CW-1:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + din;
        end
    end

endmodule

// File: rtl/mash_sinc3_decimator.sv
// rtl/mash_sinc3_decimator.sv - sinc3 CIC decimator recovering the HK-MASH 1-1-1 input word
//
// Ports:
//   clk   clock
//   rst   asynchronous reset, active-high
//   dec   mash_sinc3_decimator_if.slave: in_valid_i/y_i samples in, valid_o/y_o/x_o/settled_o out
// Parameters:
//   WIDTH     width of recovered word x_o (equals modulator WIDTH)
//   DEC_LOG2  log2 of decimation ratio R; WIDTH >= 3*DEC_LOG2
//   CW        internal width, derived from DEC_LOG2; do not override
// Build option:
//   DECIM_SAT_EN  defined: x_o clamps to 0 .. 2**WIDTH-1; undefined: x_o keeps the low WIDTH bits
//
// Pipeline: the edge accepting the R-th sample of a block raises dec_stb; the next edge runs the
// combs into comb_q; the edge after that registers y_o/x_o and pulses valid_o.

module mash_sinc3_decimator
    import mash_decim_pkg::*;
#(
    parameter int WIDTH    = 20,
    parameter int DEC_LOG2 = 6,
    parameter int CW       = cic_cw(DEC_LOG2)
) (
    input  logic                 clk,
    input  logic                 rst,
    mash_sinc3_decimator_if.slave dec
);

    // Left shift that maps the R**3 DC gain onto the WIDTH-bit input word scale.
    localparam int SH = WIDTH - ORDER * DEC_LOG2;

    logic                 accept;
    logic signed [CW-1:0] y_ext;
    logic signed [CW-1:0] int1, int2, int3;

    logic [DEC_LOG2-1:0]  cnt;
    logic                 dec_stb;

    logic signed [CW-1:0] dly1, dly2, dly3;
    logic signed [CW-1:0] c1, c2, c3;
    logic signed [CW-1:0] comb_q;
    logic                 out_stb;

    logic [WIDTH-1:0]     x_next;
    logic [1:0]           n_pulse;

    assign accept = dec.in_valid_i;
    assign y_ext  = CW'($signed(dec.y_i));

    // Integrators all register on the same edge, so each stage adds the previous
    // stage's old value: a pipelined chain with no long carry path across stages.
    cic_int_stage #(.CW(CW)) u_int1 (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .din (y_ext),
        .acc (int1)
    );

    cic_int_stage #(.CW(CW)) u_int2 (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .din (int1),
        .acc (int2)
    );

    cic_int_stage #(.CW(CW)) u_int3 (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .din (int2),
        .acc (int3)
    );

    // Decimation counter: counts accepted samples only, so gaps in in_valid_i
    // stretch the output spacing but never change which samples form a block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dec_stb <= 1'b0;
        end else begin
            dec_stb <= 1'b0;
            if (accept) begin
                cnt     <= cnt + 1'b1;
                dec_stb <= &cnt;
            end
        end
    end

    // Combs run at the decimated rate; wrap-around in the integrators cancels here.
    always_comb begin
        c1 = int3 - dly1;
        c2 = c1 - dly2;
        c3 = c2 - dly3;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly1    <= '0;
            dly2    <= '0;
            dly3    <= '0;
            comb_q  <= '0;
            out_stb <= 1'b0;
        end else begin
            out_stb <= dec_stb;
            if (dec_stb) begin
                dly1   <= int3;
                dly2   <= c1;
                dly3   <= c2;
                comb_q <= c3;
            end
        end
    end

`ifdef DECIM_SAT_EN
    localparam int SW = CW + SH;

    logic signed [SW-1:0] shifted;

    always_comb begin
        shifted = SW'(comb_q) <<< SH;
        x_next  = shifted[WIDTH-1:0];
        if (shifted[SW-1]) begin
            x_next = '0;
        end else if (|shifted[SW-2:WIDTH]) begin
            x_next = '1;
        end
    end
`else
    // Truncating before the shift keeps exactly the low WIDTH bits of the shifted value.
    assign x_next = WIDTH'(comb_q) << SH;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec.valid_o   <= 1'b0;
            dec.y_o       <= '0;
            dec.x_o       <= '0;
            dec.settled_o <= 1'b0;
            n_pulse       <= '0;
        end else begin
            dec.valid_o <= out_stb;
            if (out_stb) begin
                dec.y_o <= comb_q;
                dec.x_o <= x_next;
                // The third result is the first whose whole impulse response lies after reset.
                if (n_pulse == 2'd2) begin
                    dec.settled_o <= 1'b1;
                end else begin
                    n_pulse <= n_pulse + 2'd1;
                end
            end
        end
    end

endmodule
